fifo_rr_arbiter: RTL and testbench

//  Shares the single write port of the BRAM FIFO between N_REQ valid/ready stream producers.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rr_arbiter_if.sv | 30 +++
 rtl/fifo_rr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_rr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding, default width,
// and a clog2 helper for sizing index fields.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 72;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Requester streams plus the FIFO write-side stream shared by the round-robin arbiter.
// The slave modport is the arbiter's view; master is the producer/FIFO environment.
interface fifo_rr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LOG_N = 2
);

  logic [N_REQ*WIDTH-1:0] s_data;
  logic [N_REQ-1:0]       s_valid;
  logic [N_REQ-1:0]       s_last;
  logic [N_REQ-1:0]       s_ready;
  logic [WIDTH-1:0]       m_data;
  logic [LOG_N-1:0]       m_src;
  logic                   m_valid;
  logic                   m_ready;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_src, m_valid
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_src, m_valid
  );

endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LOG_N = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LOG_N-1:0] ptr,
  output logic [LOG_N-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned pos;
    pos = 0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (int'(ptr) + k) % N_REQ;
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = LOG_N'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin, burst-granular arbiter feeding the BRAM FIFO write port through a
// 1-deep registered output stage; each beat carries its source index.
module fifo_rr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned LOG_N     = 2,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned LOG_BURST = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  fifo_rr_arbiter_if.slave        bus,
  output logic [LOG_N-1:0]        grant,
  output logic                    busy
);

  state_e               state_q, state_d;
  logic [LOG_N-1:0]     grant_q, grant_d;
  logic [LOG_N-1:0]     ptr_q, ptr_d;
  logic [LOG_BURST-1:0] cnt_q, cnt_d;
  logic                 m_valid_q, m_valid_d;
  logic [WIDTH-1:0]     m_data_q, m_data_d;
  logic [LOG_N-1:0]     m_src_q, m_src_d;
  logic [N_REQ-1:0]     s_ready;
  logic                 ready_g;
  logic [LOG_N-1:0]     pick_idx;
  logic                 pick_any;

  rr_pick #(
    .N_REQ(N_REQ),
    .LOG_N(LOG_N)
  ) u_pick (
    .req(bus.s_valid),
    .ptr(ptr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;
    // A held beat drains whenever the FIFO takes it; a new accept below refills.
    m_valid_d = m_valid_q & ~bus.m_ready;
    s_ready   = '0;
    ready_g   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        ready_g          = ~m_valid_q | bus.m_ready;
        s_ready[grant_q] = ready_g;
        if (bus.s_valid[grant_q] && ready_g) begin
          m_data_d  = bus.s_data[int'(grant_q)*WIDTH +: WIDTH];
          m_src_d   = grant_q;
          m_valid_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (bus.s_last[grant_q] || (cnt_q == LOG_BURST'(MAX_BURST - 1))) begin
            state_d = ST_IDLE;
            ptr_d   = (grant_q == LOG_N'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_src_q   <= m_src_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_data  = m_data_q;
  assign bus.m_src   = m_src_q;
  assign bus.m_valid = m_valid_q;
  assign grant       = grant_q;
  assign busy        = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: a cycle-by-cycle vector table plus stream
// sequences checked against hand-derived beat orders and timings.
module tb_fifo_rr_arbiter;

  localparam int W = 72;
  localparam int N = 4;

  logic       clk;
  logic       resetn;
  logic [1:0] grant;
  logic       busy;

  fifo_rr_arbiter_if #(.WIDTH(W), .N_REQ(N), .LOG_N(2)) bus ();

  fifo_rr_arbiter #(
    .WIDTH(W), .N_REQ(N), .LOG_N(2), .MAX_BURST(16), .LOG_BURST(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .grant(grant),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_data(input int src, input int sq);
    return {48'h0, 8'(src), 16'(sq)};
  endfunction

  // ---------------- stream producer model ----------------
  typedef struct {
    int             src;
    logic [W-1:0]   data;
    int             t;
  } beat_t;

  beat_t           log_q[$];
  int              rem[N];
  int              seq[N];
  int              last_every[N];
  int              start_cyc[N];
  int              cyc;
  int              stall_lo, stall_hi;
  bit              prev_hold;
  logic [W-1:0]    prev_data;
  logic [1:0]      prev_src;

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; seq[i] = 0; last_every[i] = 0; start_cyc[i] = 0;
    end
    log_q.delete();
    cyc = 0; stall_lo = -1; stall_hi = -1; prev_hold = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.s_valid = '0; bus.s_last = '0; bus.s_data = '0; bus.m_ready = 1'b1;
    clear_model();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.s_valid[i] = (cyc >= start_cyc[i]) && (rem[i] > 0);
      bus.s_last[i]  = bus.s_valid[i] && (last_every[i] > 0) &&
                       (((seq[i] + 1) % last_every[i]) == 0);
      bus.s_data[i*W +: W] = mk_data(i, seq[i]);
    end
    bus.m_ready = !((cyc >= stall_lo) && (cyc < stall_hi));
    #1;
    chk("sready_onehot0", W'($onehot0(bus.s_ready)), W'(1));
    if (bus.s_ready != '0) begin
      chk("sready_needs_busy", W'(busy), W'(1));
      chk("sready_at_grant", W'(bus.s_ready[grant]), W'(1));
    end
    if (bus.m_valid && !bus.m_ready) chk("sready_when_full", W'(bus.s_ready), W'(0));
    if (prev_hold) begin
      chk("hold_m_valid", W'(bus.m_valid), W'(1));
      chk("hold_m_data", bus.m_data, prev_data);
      chk("hold_m_src", W'(bus.m_src), W'(prev_src));
    end
    if (bus.m_valid && bus.m_ready) log_q.push_back('{int'(bus.m_src), bus.m_data, cyc});
    for (int i = 0; i < N; i++) begin
      if (bus.s_valid[i] && bus.s_ready[i]) begin
        seq[i]++;
        rem[i]--;
      end
    end
    prev_hold = bus.m_valid && !bus.m_ready;
    prev_data = bus.m_data;
    prev_src  = bus.m_src;
    cyc++;
  endtask

  task automatic chk_beat(input string name, input int k, input int src, input int sq);
    if (k < log_q.size()) begin
      chk({name, "_src"}, W'(log_q[k].src), W'(src));
      chk({name, "_data"}, log_q[k].data, mk_data(src, sq));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] sv;
    logic [3:0] sl;
    logic       mr;
    logic [3:0] e_sr;
    logic       e_mv;
    logic [1:0] e_src;
    logic       e_busy;
    logic [1:0] e_grant;
  } vec_t;

  vec_t vecs[10];

  initial begin
    resetn = 1'b0;
    bus.s_valid = '0; bus.s_last = '0; bus.s_data = '0; bus.m_ready = 1'b1;

    vecs[0] = '{4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[1] = '{4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 2'd0};
    vecs[2] = '{4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0};
    vecs[3] = '{4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd1};
    vecs[4] = '{4'b0001, 4'b0011, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 2'd0};
    vecs[5] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 2'd0};
    vecs[6] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd0};
    vecs[7] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 2'd0};
    vecs[8] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0};
    vecs[9] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0};

    // Reset held with everyone requesting, then the first grant goes to 0.
    @(negedge clk);
    bus.s_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_ready", W'(bus.s_ready), W'(0));
    chk("rst_m_valid", W'(bus.m_valid), W'(0));
    chk("rst_m_data", bus.m_data, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("first_busy", W'(busy), W'(1));
    chk("first_grant", W'(grant), W'(0));

    // Cycle-accurate vector table.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      bus.s_valid = vecs[r].sv;
      bus.s_last  = vecs[r].sl;
      bus.m_ready = vecs[r].mr;
      for (int i = 0; i < N; i++) bus.s_data[i*W +: W] = mk_data(i, 0);
      #1;
      chk($sformatf("vec%0d_s_ready", r), W'(bus.s_ready), W'(vecs[r].e_sr));
      chk($sformatf("vec%0d_m_valid", r), W'(bus.m_valid), W'(vecs[r].e_mv));
      chk($sformatf("vec%0d_busy", r), W'(busy), W'(vecs[r].e_busy));
      if (vecs[r].e_mv) begin
        chk($sformatf("vec%0d_m_src", r), W'(bus.m_src), W'(vecs[r].e_src));
        chk($sformatf("vec%0d_m_data", r), bus.m_data, mk_data(vecs[r].e_src, 0));
      end
      if (vecs[r].e_busy) chk($sformatf("vec%0d_grant", r), W'(grant), W'(vecs[r].e_grant));
    end

    // Round-robin: four requesters, 2-beat bursts, two rounds.
    do_reset();
    for (int i = 0; i < N; i++) begin rem[i] = 4; last_every[i] = 2; end
    for (int c = 0; c < 200 && log_q.size() < 16; c++) run_cycle();
    chk("rr_count", W'(log_q.size()), W'(16));
    for (int k = 0; k < 16; k++) begin
      chk_beat($sformatf("rr_beat%0d", k), k, (k % 8) / 2, (k / 8) * 2 + (k % 2));
      if (k > 0 && k < log_q.size())
        chk($sformatf("rr_gap%0d", k), W'(log_q[k].t - log_q[k-1].t), W'((k % 2) ? 1 : 2));
    end

    // Burst cap: 2 streams 20 beats without last while 1 waits.
    do_reset();
    rem[2] = 20;
    rem[1] = 1; last_every[1] = 1; start_cyc[1] = 3;
    for (int c = 0; c < 200 && log_q.size() < 21; c++) run_cycle();
    chk("cap_count", W'(log_q.size()), W'(21));
    for (int k = 0; k < 21; k++) begin
      if (k < 16)       chk_beat($sformatf("cap_beat%0d", k), k, 2, k);
      else if (k == 16) chk_beat("cap_beat16", k, 1, 0);
      else              chk_beat($sformatf("cap_beat%0d", k), k, 2, k - 1);
    end

    // Backpressure mid-burst; the cap still lands after 16 beats.
    do_reset();
    rem[0] = 20;
    rem[3] = 1; last_every[3] = 1; start_cyc[3] = 2;
    stall_lo = 6; stall_hi = 11;
    for (int c = 0; c < 200 && log_q.size() < 21; c++) run_cycle();
    chk("bp_count", W'(log_q.size()), W'(21));
    for (int k = 0; k < 21; k++) begin
      if (k < 16)       chk_beat($sformatf("bp_beat%0d", k), k, 0, k);
      else if (k == 16) chk_beat("bp_beat16", k, 3, 0);
      else              chk_beat($sformatf("bp_beat%0d", k), k, 0, k - 1);
    end

    // Asynchronous reset while a beat is held; pointer returns to 0.
    do_reset();
    rem[1] = 1; last_every[1] = 1;
    rem[2] = 10;
    for (int c = 0; c < 5; c++) run_cycle();
    chk("arst_pre_m_valid", W'(bus.m_valid), W'(1));
    chk("arst_pre_grant", W'(grant), W'(2));
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_m_valid", W'(bus.m_valid), W'(0));
    chk("arst_s_ready", W'(bus.s_ready), W'(0));
    chk("arst_busy", W'(busy), W'(0));
    bus.s_valid = 4'hF;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_post_busy", W'(busy), W'(1));
    chk("arst_post_grant", W'(grant), W'(0));

    // Sparse: only requester 3, single-beat bursts.
    do_reset();
    rem[3] = 6; last_every[3] = 1;
    for (int c = 0; c < 60 && log_q.size() < 6; c++) begin
      run_cycle();
      chk("sparse_other_ready", W'(bus.s_ready & 4'b0111), W'(0));
      if (busy) chk("sparse_grant", W'(grant), W'(3));
    end
    chk("sparse_count", W'(log_q.size()), W'(6));
    for (int k = 0; k < 6; k++) begin
      chk_beat($sformatf("sparse_beat%0d", k), k, 3, k);
      if (k > 0 && k < log_q.size())
        chk($sformatf("sparse_gap%0d", k), W'(log_q[k].t - log_q[k-1].t), W'(2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
